// File: rtl/crc_stream_pkg.sv
// Shared types, CRC-32 default constants and bit-level helpers for crc_stream_engine.
package crc_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StTail
    } crc_state_e;

    localparam logic [63:0] CRC32_POLY    = 64'h0000_0000_04C1_1DB7;
    localparam logic [63:0] CRC32_INIT    = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] CRC32_XOR_OUT = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] CRC32_RESIDUE = 64'h0000_0000_C704_DD7B;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int unsigned w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(w)) begin
                r[6'(i)] = v[6'(int'(w) - 1 - i)];
            end
        end
        return r;
    endfunction

    // One shift of a normal-form register. With reflect set, bit_pos 0 of a byte is the
    // byte's LSB, so bytes enter LSB first; otherwise MSB first.
    function automatic logic [63:0] lfsr_step(
        input logic [63:0]  crc,
        input logic [7:0]   byte_in,
        input int unsigned  bit_pos,
        input logic [63:0]  poly,
        input int unsigned  width,
        input logic         reflect
    );
        logic        din;
        logic        fb;
        logic [63:0] mask;
        din  = reflect ? byte_in[3'(bit_pos)] : byte_in[3'(7 - bit_pos)];
        fb   = crc[6'(width - 1)] ^ din;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ((crc << 1) ^ (fb ? poly : 64'd0)) & mask;
    endfunction

endpackage

// File: rtl/crc_stream_engine_lfsr_step.sv
// Combinational CRC register update over NBITS input bits, byte 0 (data[7:0]) first.
module crc_lfsr_step
    import crc_stream_pkg::*;
#(
    parameter int unsigned CRC_W   = 32,
    parameter int unsigned NBITS   = 8,
    parameter logic [63:0] POLY    = CRC32_POLY,
    parameter bit          REFLECT = 1'b1
) (
    input  logic [CRC_W-1:0] crc_cur,
    input  logic [NBITS-1:0] data,
    output logic [CRC_W-1:0] crc_next
);

    localparam int unsigned NBYTES = NBITS / 8;

    logic [63:0] c;

    always_comb begin
        c = 64'(crc_cur);
        for (int unsigned b = 0; b < NBYTES; b++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                c = lfsr_step(c, 8'(data >> (b * 8)), j, POLY, CRC_W, REFLECT);
            end
        end
        crc_next = c[CRC_W-1:0];
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed streaming CRC generator: full beats in one cycle, partial last beat byte-serially.
// Define CRC_CHECK_EN to add the crc_ok residue comparator and port.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CRC_W   = 32,
    parameter logic [63:0] POLY    = CRC32_POLY,
    parameter logic [63:0] INIT    = CRC32_INIT,
    parameter logic [63:0] XOR_OUT = CRC32_XOR_OUT,
    parameter bit          REFLECT = 1'b1
`ifdef CRC_CHECK_EN
    ,
    parameter logic [63:0] RESIDUE = CRC32_RESIDUE
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [((DATA_W > 8) ? $clog2(DATA_W / 8) : 1)-1:0] in_nbytes,
    input  logic [DATA_W-1:0]   in_data,
    output logic                crc_valid,
    output logic [CRC_W-1:0]    crc_out,
    output logic                frame_err
`ifdef CRC_CHECK_EN
    ,
    output logic                crc_ok
`endif
);

    localparam int unsigned    NB_W   = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;
    localparam logic [CRC_W-1:0] INIT_V = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_V  = XOR_OUT[CRC_W-1:0];

    crc_state_e         st_q, st_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [DATA_W-1:0]  tail_data_q, tail_data_d;
    logic [NB_W-1:0]    tail_cnt_q, tail_cnt_d;
    logic               crc_valid_q, crc_valid_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;
    logic               frame_err_q, frame_err_d;

    logic               accept;
    logic [CRC_W-1:0]   crc_seed;
    logic [CRC_W-1:0]   crc_full;
    logic [CRC_W-1:0]   crc_byte;
    logic               res_fire;
    logic [CRC_W-1:0]   res_reg;
    logic [63:0]        res_rev;
    logic [CRC_W-1:0]   res_fin;

    assign in_ready = (st_q != StTail);
    assign accept   = in_valid && in_ready;
    assign crc_seed = in_sof ? INIT_V : crc_q;

    crc_lfsr_step #(
        .CRC_W   (CRC_W),
        .NBITS   (DATA_W),
        .POLY    (POLY),
        .REFLECT (REFLECT)
    ) u_step_beat (
        .crc_cur  (crc_seed),
        .data     (in_data),
        .crc_next (crc_full)
    );

    crc_lfsr_step #(
        .CRC_W   (CRC_W),
        .NBITS   (8),
        .POLY    (POLY),
        .REFLECT (REFLECT)
    ) u_step_byte (
        .crc_cur  (crc_q),
        .data     (tail_data_q[7:0]),
        .crc_next (crc_byte)
    );

    always_comb begin
        st_d        = st_q;
        crc_d       = crc_q;
        tail_data_d = tail_data_q;
        tail_cnt_d  = tail_cnt_q;
        crc_valid_d = 1'b0;
        frame_err_d = 1'b0;
        res_fire    = 1'b0;
        res_reg     = crc_q;

        unique case (st_q)
            StIdle, StRun: begin
                if (accept) begin
                    if (in_sof || st_q == StRun) begin
                        // A new sof while running abandons the open frame.
                        if (in_sof && st_q == StRun) begin
                            frame_err_d = 1'b1;
                        end
                        if (in_eof && in_nbytes != '0) begin
                            st_d        = StTail;
                            crc_d       = crc_seed;
                            tail_data_d = in_data;
                            tail_cnt_d  = in_nbytes;
                        end else begin
                            crc_d = crc_full;
                            if (in_eof) begin
                                st_d     = StIdle;
                                res_fire = 1'b1;
                                res_reg  = crc_full;
                            end else begin
                                st_d = StRun;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StTail: begin
                crc_d       = crc_byte;
                tail_data_d = tail_data_q >> 8;
                tail_cnt_d  = tail_cnt_q - NB_W'(1);
                if (tail_cnt_q == NB_W'(1)) begin
                    st_d     = StIdle;
                    res_fire = 1'b1;
                    res_reg  = crc_byte;
                end
            end
            default: st_d = StIdle;
        endcase

        res_rev     = bitrev(64'(res_reg), CRC_W);
        res_fin     = (REFLECT ? res_rev[CRC_W-1:0] : res_reg) ^ XOR_V;
        crc_valid_d = res_fire;
        crc_out_d   = res_fire ? res_fin : crc_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            crc_q       <= INIT_V;
            tail_data_q <= '0;
            tail_cnt_q  <= '0;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            crc_q       <= crc_d;
            tail_data_q <= tail_data_d;
            tail_cnt_q  <= tail_cnt_d;
            crc_valid_q <= crc_valid_d;
            crc_out_q   <= crc_out_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign crc_valid = crc_valid_q;
    assign crc_out   = crc_out_q;
    assign frame_err = frame_err_q;

`ifdef CRC_CHECK_EN
    localparam logic [CRC_W-1:0] RESIDUE_V = RESIDUE[CRC_W-1:0];

    logic crc_ok_q;

    // Compares the raw register, before reversal and output XOR.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_ok_q <= 1'b0;
        end else if (res_fire) begin
            crc_ok_q <= (res_reg == RESIDUE_V);
        end
    end

    assign crc_ok = crc_ok_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: directed CRC-32 vectors plus random frames
// checked against a byte-wise reflected CRC-32 model. Honours CRC_CHECK_EN when defined.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT a: 64-bit beats
    logic        a_valid, a_ready, a_sof, a_eof;
    logic [2:0]  a_nbytes;
    logic [63:0] a_data;
    logic        a_crc_valid, a_frame_err;
    logic [31:0] a_crc_out;
`ifdef CRC_CHECK_EN
    logic        a_crc_ok;
`endif

    // DUT b: 8-bit beats
    logic        b_valid, b_ready, b_sof, b_eof;
    logic [0:0]  b_nbytes;
    logic [7:0]  b_data;
    logic        b_crc_valid, b_frame_err;
    logic [31:0] b_crc_out;
`ifdef CRC_CHECK_EN
    logic        b_crc_ok;
`endif

    crc_stream_engine #(.DATA_W(64)) u_dut_a (
`ifdef CRC_CHECK_EN
        .crc_ok    (a_crc_ok),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_sof    (a_sof),
        .in_eof    (a_eof),
        .in_nbytes (a_nbytes),
        .in_data   (a_data),
        .crc_valid (a_crc_valid),
        .crc_out   (a_crc_out),
        .frame_err (a_frame_err)
    );

    crc_stream_engine #(.DATA_W(8)) u_dut_b (
`ifdef CRC_CHECK_EN
        .crc_ok    (b_crc_ok),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_sof    (b_sof),
        .in_eof    (b_eof),
        .in_nbytes (b_nbytes),
        .in_data   (b_data),
        .crc_valid (b_crc_valid),
        .crc_out   (b_crc_out),
        .frame_err (b_frame_err)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic        ok_q[$];
    int          err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_crc_valid) begin
            got_q.push_back(a_crc_out);
            got_cyc.push_back(cyc);
`ifdef CRC_CHECK_EN
            ok_q.push_back(a_crc_ok);
`endif
        end
        if (a_frame_err) err_pulses <= err_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reflected (LSB-first, right-shifting) CRC-32 over a byte list.
    function automatic logic [31:0] crc32_ref(input logic [7:0] bytes[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (bytes[i]) begin
            c ^= {24'd0, bytes[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_a(input logic sof, input logic eof, input logic [2:0] nb,
                          input logic [63:0] d);
        int w = 0;
        a_valid = 1'b1; a_sof = sof; a_eof = eof; a_nbytes = nb; a_data = d;
        while (!a_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!a_ready) chk("in_ready_wait", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0;
    endtask

    task automatic send_ref_a();
        send_a(1'b1, 1'b0, 3'd0, 64'h3837_3635_3433_3231);
        send_a(1'b0, 1'b1, 3'd1, 64'h39);
    endtask

    task automatic wait_res(input int n0, input int want, input int budget);
        int k = 0;
        while (got_q.size() - n0 < want && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int          n0, e0;
        logic [63:0] d1, d2;
        logic [7:0]  fb[$];
        logic [31:0] exp_q[$];

        rst = 1'b1;
        a_valid = 0; a_sof = 0; a_eof = 0; a_nbytes = 0; a_data = 0;
        b_valid = 0; b_sof = 0; b_eof = 0; b_nbytes = 0; b_data = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_valid", 32'(a_crc_valid), 32'd0);
        chk("rst_crc_out", a_crc_out, 32'd0);
        chk("rst_frame_err", 32'(a_frame_err), 32'd0);
        chk("rst_b_crc_out", b_crc_out, 32'd0);

        // Reference vector, partial last beat of one byte
        send_ref_a();
        chk("tail_ready_low", 32'(a_ready), 32'd0);
        chk("tail_no_valid", 32'(a_crc_valid), 32'd0);
        @(negedge clk);
        chk("ref_ready_back", 32'(a_ready), 32'd1);
        chk("ref_valid", 32'(a_crc_valid), 32'd1);
        chk("ref_crc", a_crc_out, 32'hCBF4_3926);
        @(negedge clk);
        chk("valid_one_cycle", 32'(a_crc_valid), 32'd0);
        chk("crc_held", a_crc_out, 32'hCBF4_3926);

        // Same bytes on the 8-bit instance
        for (int i = 0; i < 9; i++) begin
            b_valid = 1'b1; b_sof = (i == 0); b_eof = (i == 8); b_data = 8'(8'h31 + i);
            @(negedge clk);
        end
        b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0;
        chk("b_valid", 32'(b_crc_valid), 32'd1);
        chk("b_crc", b_crc_out, 32'hCBF4_3926);
        chk("b_no_err", 32'(b_frame_err), 32'd0);

        // Reset during the third TAIL cycle
        n0 = got_q.size();
        send_a(1'b1, 1'b0, 3'd0, {$urandom(), $urandom()});
        send_a(1'b0, 1'b1, 3'd7, {$urandom(), $urandom()});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midtail_rst_ready", 32'(a_ready), 32'd1);
        chk("midtail_rst_crc_out", a_crc_out, 32'd0);
        repeat (10) @(negedge clk);
        chk("midtail_rst_no_result", got_q.size() - n0, 0);
        n0 = got_q.size();
        send_ref_a();
        wait_res(n0, 1, 20);
        chk("post_rst_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("post_rst_crc", got_q[n0], 32'hCBF4_3926);

        // sof while a frame is open
        n0 = got_q.size();
        e0 = err_pulses;
        send_a(1'b1, 1'b0, 3'd0, {$urandom(), $urandom()});
        send_ref_a();
        wait_res(n0, 1, 20);
        repeat (3) @(negedge clk);
        chk("abort_err_pulses", err_pulses - e0, 1);
        chk("abort_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("abort_crc", got_q[n0], 32'hCBF4_3926);

        // Stray beat in IDLE, then back-to-back single-beat frames
        n0 = got_q.size();
        e0 = err_pulses;
        send_a(1'b0, 1'b0, 3'd0, {$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        chk("stray_err_pulses", err_pulses - e0, 1);
        chk("stray_no_result", got_q.size() - n0, 0);
        d1 = {$urandom(), $urandom()};
        d2 = {$urandom(), $urandom()};
        send_a(1'b1, 1'b1, 3'd0, d1);
        send_a(1'b1, 1'b1, 3'd0, d2);
        wait_res(n0, 2, 20);
        chk("b2b_count", got_q.size() - n0, 2);
        if (got_q.size() >= n0 + 2) begin
            chk("b2b_gap", got_cyc[n0 + 1] - got_cyc[n0], 1);
            fb.delete();
            for (int i = 0; i < 8; i++) fb.push_back(8'(d1 >> (8 * i)));
            chk("b2b_crc0", got_q[n0], crc32_ref(fb));
            fb.delete();
            for (int i = 0; i < 8; i++) fb.push_back(8'(d2 >> (8 * i)));
            chk("b2b_crc1", got_q[n0 + 1], crc32_ref(fb));
        end

        // Random frames with idle gaps and random partial tails
        n0 = got_q.size();
        e0 = err_pulses;
        for (int f = 0; f < 40; f++) begin
            int          nbeats;
            logic [2:0]  nb;
            int          nb_eff;
            logic [63:0] d;
            nbeats = int'($urandom_range(1, 4));
            fb.delete();
            for (int bt = 0; bt < nbeats; bt++) begin
                d = {$urandom(), $urandom()};
                nb = (bt == nbeats - 1) ? 3'($urandom_range(0, 7)) : 3'd0;
                nb_eff = (nb == 0) ? 8 : int'(nb);
                for (int i = 0; i < nb_eff; i++) fb.push_back(8'(d >> (8 * i)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_a(bt == 0, bt == nbeats - 1, nb, d);
            end
            exp_q.push_back(crc32_ref(fb));
        end
        wait_res(n0, 40, 200);
        repeat (10) @(negedge clk);
        chk("rand_count", got_q.size() - n0, 40);
        chk("rand_no_err", err_pulses - e0, 0);
        for (int i = 0; i < 40; i++) begin
            if (got_q.size() > n0 + i) chk($sformatf("rand_crc%0d", i), got_q[n0 + i], exp_q[i]);
        end

`ifdef CRC_CHECK_EN
        n0 = got_q.size();
        send_a(1'b1, 1'b0, 3'd0, 64'h3837_3635_3433_3231);
        send_a(1'b0, 1'b1, 3'd5, 64'hCB_F439_2639);
        wait_res(n0, 1, 20);
        chk("residue_count", got_q.size() - n0, 1);
        if (ok_q.size() > n0) chk("residue_ok", 32'(ok_q[n0]), 32'd1);
        n0 = got_q.size();
        send_a(1'b1, 1'b0, 3'd0, 64'h3837_3635_3433_3230);
        send_a(1'b0, 1'b1, 3'd5, 64'hCB_F439_2639);
        wait_res(n0, 1, 20);
        chk("residue_bad_count", got_q.size() - n0, 1);
        if (ok_q.size() > n0) chk("residue_bad", 32'(ok_q[n0]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
